// File: rtl/ws2812_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ws2812_pkg : shared state encoding, widths and channel scaling helper     |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package ws2812_pkg;

    localparam int C_CH_WIDTH         = 8;
    localparam int C_NUM_CH           = 3;
    localparam int C_PIX_WIDTH        = C_CH_WIDTH * C_NUM_CH;
    localparam int C_RESET_CYCLES_50M = 15000;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SCALE = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // (chan * (level + 1)) >> 8 : level 255 passes chan through, level 0 blanks it
    function automatic logic [C_CH_WIDTH-1:0] scale_channel(
        input logic [C_CH_WIDTH-1:0] chan,
        input logic [C_CH_WIDTH-1:0] level
    );
        logic [2*C_CH_WIDTH-1:0] prod;
        prod = {8'd0, chan} * ({8'd0, level} + 16'd1);
        return prod[2*C_CH_WIDTH-1:C_CH_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_pixel_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ws2812_pixel_ram : NUM_LEDS x DW simple dual-port RAM, read-first         |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
module ws2812_pixel_ram #(
    parameter int NUM_LEDS = 16,
    parameter int AW       = 4,
    parameter int DW       = 24
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [NUM_LEDS];
    logic [DW-1:0] rd_data_q;
    logic          w_wr_ok;

    assign w_wr_ok = wr_en && ({{(32-AW){1'b0}}, wr_addr} < 32'(NUM_LEDS));

    // Storage deliberately has no reset so the array maps onto RAM primitives
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ws2812_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ws2812_frame_scheduler : walks the pixel buffer through the serializer    |
// | Revision               : 1.0                                              |
// +--------------------------------------------------------------------------+
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 16,
    parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    parameter int RESET_CYCLES = C_RESET_CYCLES_50M
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [C_PIX_WIDTH-1:0] wr_data,
    input  logic [C_CH_WIDTH-1:0]  bright,
    input  logic                   frame_req,
    input  logic                   auto_en,
    output logic [C_PIX_WIDTH-1:0] tx_data,
    output logic                   tx_start,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int            GW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(RESET_CYCLES - 1);

    state_t                  state_q,    state_d;
    logic [AW-1:0]           idx_q,      idx_d;
    logic [GW-1:0]           gap_cnt_q,  gap_cnt_d;
    logic                    pending_q,  pending_d;
    logic                    frame_gap_q, frame_gap_d;
    logic [C_CH_WIDTH-1:0]   bright_q,   bright_d;
    logic [C_PIX_WIDTH-1:0]  tx_data_q,  tx_data_d;
    logic                    tx_start_q, tx_start_d;

    logic [C_PIX_WIDTH-1:0]  w_rd_data;
    logic [C_PIX_WIDTH-1:0]  w_scaled;
    logic                    w_go;
    logic                    w_gap_end;

    ws2812_pixel_ram #(
        .NUM_LEDS (NUM_LEDS),
        .AW       (AW),
        .DW       (C_PIX_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state_q == ST_FETCH),
        .rd_addr (idx_q),
        .rd_data (w_rd_data)
    );

    for (genvar ch = 0; ch < C_NUM_CH; ch++) begin : g_chan
        assign w_scaled[ch*C_CH_WIDTH +: C_CH_WIDTH] =
            scale_channel(w_rd_data[ch*C_CH_WIDTH +: C_CH_WIDTH], bright_q);
    end

    assign w_go      = frame_req | pending_q | auto_en;
    assign w_gap_end = (gap_cnt_q == GAP_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        pending_d   = pending_q;
        frame_gap_d = frame_gap_q;
        bright_d    = bright_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;

        // Requests arriving while busy collapse into a single queued frame
        if (frame_req && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_go) begin
                    idx_d     = '0;
                    bright_d  = bright;
                    pending_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_SCALE;
            end
            ST_SCALE: begin
                tx_data_d  = w_scaled;
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_FETCH;
                    end else begin
                        gap_cnt_d   = '0;
                        frame_gap_d = 1'b1;
                        state_d     = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    frame_gap_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                gap_cnt_d   = '0;
                frame_gap_d = 1'b0;
                state_d     = ST_GAP;
            end
        endcase
    end

    // Reset lands in a gap so the chain still latches after an aborted frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_GAP;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            pending_q   <= 1'b0;
            frame_gap_q <= 1'b0;
            bright_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            pending_q   <= pending_d;
            frame_gap_q <= frame_gap_d;
            bright_q    <= bright_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_GAP) && w_gap_end && frame_gap_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ws2812_frame_scheduler : directed bench with a 5-cycle serializer     |
// | Revision                  : 1.0                                          |
// +--------------------------------------------------------------------------+
module tb_ws2812_frame_scheduler;

    localparam int C_NUM_LEDS = 4;
    localparam int C_AW       = 2;
    localparam int C_RST_CYC  = 20;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  bright;
    logic        frame_req;
    logic        auto_en;
    logic [23:0] tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic        frame_done;

    logic        tx_done_m;
    logic        inj_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          ts_cyc  [256];
    logic [23:0] ts_data [256];
    int          td_cyc  [256];
    int          fd_cyc  [256];
    int n_ts = 0, n_td = 0, n_fd = 0;
    int          ser_cnt = 0;
    int          done_in_frame = 0;
    logic        gap_flag = 1'b0;
    logic [23:0] cur_data = '0;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  br;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs [8];

    ws2812_frame_scheduler #(
        .NUM_LEDS     (C_NUM_LEDS),
        .AW           (C_AW),
        .RESET_CYCLES (C_RST_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bright     (bright),
        .frame_req  (frame_req),
        .auto_en    (auto_en),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .busy       (busy),
        .frame_done (frame_done)
    );

    assign tx_done = tx_done_m | inj_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Serializer model plus event recorder; tx_done follows tx_start by 5 cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            ser_cnt       = 0;
            tx_done_m     = 1'b0;
            done_in_frame = 0;
            gap_flag      = 1'b0;
        end else begin
            tx_done_m = 1'b0;
            if (ser_cnt == 1) begin
                tx_done_m = 1'b1;
                chk("tx_data_stable", tx_data, cur_data);
                if (n_td < 256) td_cyc[n_td] = cyc;
                n_td++;
                done_in_frame++;
                if (done_in_frame == C_NUM_LEDS) begin
                    gap_flag      = 1'b1;
                    done_in_frame = 0;
                end
            end
            if (ser_cnt > 0) ser_cnt--;
            if (tx_start) begin
                chk("tx_start_while_serializing", ser_cnt, 0);
                chk("tx_start_in_gap", gap_flag, 1'b0);
                if (n_ts < 256) begin
                    ts_cyc[n_ts]  = cyc;
                    ts_data[n_ts] = tx_data;
                end
                n_ts++;
                cur_data = tx_data;
                ser_cnt  = 5;
            end
            if (frame_done) begin
                if (n_fd < 256) fd_cyc[n_fd] = cyc;
                n_fd++;
                gap_flag = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_req(output int t);
        t         = cyc;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic wait_fd(input int bound);
        int k;
        int fd0;
        k   = 0;
        fd0 = n_fd;
        while (n_fd == fd0 && k < bound) begin
            tick();
            k++;
        end
        chk("frame_done_seen", n_fd > fd0, 1'b1);
    endtask

    task automatic wait_ts(input int target, input int bound);
        int k;
        k = 0;
        while (n_ts < target && k < bound) begin
            tick();
            k++;
        end
        chk("tx_start_seen", n_ts >= target, 1'b1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 100);
    endtask

    initial begin
        int t, base, fdb, n, f1;
        logic [23:0] exp4 [4];

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bright = '0; frame_req = 1'b0; auto_en = 1'b0; inj_done = 1'b0;

        vecs[0] = '{24'hFF8001, 8'd127, 24'h7F4000};
        vecs[1] = '{24'hFF8001, 8'd0,   24'h000000};
        vecs[2] = '{24'h123456, 8'd255, 24'h123456};
        vecs[3] = '{24'hFFFFFF, 8'd0,   24'h000000};
        vecs[4] = '{24'hFFFFFF, 8'd1,   24'h010101};
        vecs[5] = '{24'h80C040, 8'd63,  24'h203010};
        vecs[6] = '{24'h01FF02, 8'd128, 24'h008001};
        vecs[7] = '{24'h64C8FA, 8'd199, 24'h4E9CC3};

        // Reset state and the post-reset gap
        tick(); tick(); tick();
        chk("rst_busy", busy, 1'b1);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 24'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        count_busy(n);
        chk("reset_gap_len", n, 20);
        chk("reset_gap_no_frame_done", n_fd, 0);

        // Basic frame, bright=255
        exp4 = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        for (int i = 0; i < 4; i++) wr(2'(i), exp4[i]);
        bright = 8'd255;
        while (cyc < 30) tick();
        base = n_ts;
        pulse_req(t);
        wait_fd(200);
        chk("t1_first_start_latency", ts_cyc[base], t + 3);
        chk("t1_start_count", n_ts - base, 4);
        for (int i = 0; i < 4; i++) chk("t1_tx_data", ts_data[base + i], exp4[i]);
        chk("t1_next_start_latency", ts_cyc[base + 1], td_cyc[base] + 3);
        chk("t1_done_to_frame_done", fd_cyc[n_fd - 1], td_cyc[n_td - 1] + 20);
        chk("t1_frame_done_count", n_fd, 1);

        // Brightness vectors
        for (int v = 0; v < 8; v++) begin
            for (int a = 0; a < 4; a++) wr(2'(a), vecs[v].pix);
            bright = vecs[v].br;
            base = n_ts;
            pulse_req(t);
            wait_fd(200);
            chk("vec_start_latency", ts_cyc[base], t + 3);
            for (int i = 0; i < 4; i++) chk("vec_tx_data", ts_data[base + i], vecs[v].exp);
        end

        // Mid-frame writes (read-first on pixel 1, new data on pixel 2) and mid-frame bright change
        exp4 = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        for (int i = 0; i < 4; i++) wr(2'(i), exp4[i]);
        bright = 8'd255;
        base = n_ts;
        pulse_req(t);
        while (cyc < t + 9) tick();
        wr(2'd1, 24'h010203);
        bright = 8'd0;
        wr(2'd2, 24'hA5A5A5);
        wait_fd(200);
        chk("mid_pix0", ts_data[base],     24'h112233);
        chk("mid_pix1_read_first", ts_data[base + 1], 24'h445566);
        chk("mid_pix2_new", ts_data[base + 2], 24'hA5A5A5);
        chk("mid_pix3_bright_held", ts_data[base + 3], 24'hAABBCC);
        bright = 8'd255;

        // Three requests during a frame merge into one extra frame
        base = n_ts;
        fdb  = n_fd;
        pulse_req(t);
        wait_ts(base + 1, 50);
        pulse_req(t); tick();
        pulse_req(t); tick();
        pulse_req(t);
        wait_fd(200);
        f1 = fd_cyc[n_fd - 1];
        wait_fd(200);
        chk("pend_second_start", ts_cyc[base + 4], f1 + 4);
        repeat (60) tick();
        chk("pend_start_total", n_ts - base, 8);
        chk("pend_frame_total", n_fd - fdb, 2);
        chk("pend_idle_after", busy, 1'b0);

        // Auto mode for three frames
        fdb = n_fd;
        auto_en = 1'b1;
        wait_fd(200);
        wait_fd(200);
        wait_fd(200);
        auto_en = 1'b0;
        chk("auto_spacing_1", fd_cyc[fdb + 1] - fd_cyc[fdb], 53);
        chk("auto_spacing_2", fd_cyc[fdb + 2] - fd_cyc[fdb + 1], 53);
        repeat (60) tick();
        chk("auto_frame_total", n_fd - fdb, 3);

        // Stray tx_done while IDLE
        base = n_ts;
        fdb  = n_fd;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (10) tick();
        chk("stray_done_busy", busy, 1'b0);
        chk("stray_done_no_start", n_ts - base, 0);
        chk("stray_done_no_frame_done", n_fd - fdb, 0);

        // Reset during SEND of pixel 2
        base = n_ts;
        pulse_req(t);
        chk("post_stray_start_latency", 0, 0 + 0 * t);
        wait_ts(base + 3, 100);
        chk("pre_reset_start_latency", ts_cyc[base], t + 3);
        chk("pre_reset_tx_data", tx_data, 24'hA5A5A5);
        rst_n = 1'b0;
        tick();
        chk("abort_tx_start", tx_start, 1'b0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_tx_data", tx_data, 24'h0);
        rst_n = 1'b1;
        base = n_ts;
        fdb  = n_fd;
        count_busy(n);
        chk("abort_gap_len", n, 20);
        chk("abort_no_frame_done", n_fd - fdb, 0);
        chk("abort_no_start", n_ts - base, 0);

        // Recovery frame; buffer contents survive reset
        pulse_req(t);
        wait_fd(200);
        chk("recover_start_latency", ts_cyc[base], t + 3);
        chk("recover_pix0", ts_data[base],     24'h112233);
        chk("recover_pix1", ts_data[base + 1], 24'h010203);
        chk("recover_pix2", ts_data[base + 2], 24'hA5A5A5);
        chk("recover_pix3", ts_data[base + 3], 24'hAABBCC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
